// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the memory port arbiter
package mem_arb_pkg;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: single-outstanding memory request bus
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;
    logic              m_req;
    logic              m_we;
    logic [WORD_W-1:0] m_addr;
    logic [WORD_W-1:0] m_wdata;
    logic [WORD_W-1:0] m_rdata;
    logic              m_ack;

    modport master (output m_req, m_we, m_addr, m_wdata, input m_rdata, m_ack);
    modport slave  (input m_req, m_we, m_addr, m_wdata, output m_rdata, m_ack);
endinterface

// File: rtl/arb_run_counter.sv
// arb_run_counter: saturating count of back-to-back data grants
module arb_run_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic data_grant,
    input  logic fetch_grant,
    output logic saturated
);
    logic [CNT_W-1:0] cnt;

    assign saturated = cnt == CNT_W'(MAX_DATA_RUN);

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            cnt <= '0;
        else if (fetch_grant)
            cnt <= '0;
        else if (data_grant && !saturated)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [WORD_W-1:0] if_instr,
    output logic              if_valid,
    output logic              if_stop,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_done,
    mem_port_arbiter_if.master m
);
    arb_state_t state, state_n;
    logic       discard, discard_n;
    logic       grant, grant_data, force_fetch;
    logic       fetch_ok, data_ack;

`ifdef ARB_STARVE_GUARD_EN
    arb_run_counter #(.MAX_DATA_RUN(MAX_DATA_RUN)) u_run (
        .clk         (clk),
        .reset       (reset),
        .data_grant  (grant && grant_data),
        .fetch_grant (grant && !grant_data),
        .saturated   (force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    // d_req is still high while its d_done pulses, so it is masked there
    assign grant      = state == IDLE || m.m_ack;
    assign grant_data = d_req && !d_done && !force_fetch;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            discard <= 1'b0;
        end else begin
            state   <= state_n;
            discard <= discard_n;
        end

    always_comb begin
        state_n   = grant ? (grant_data ? DATA : FETCH) : state;
        discard_n = state != FETCH ? discard : m.m_ack ? 1'b0 : discard || if_flush;
    end

    always_comb begin
        m.m_req  = state != IDLE;
        fetch_ok = state == FETCH && m.m_ack && !discard && !if_flush;
        data_ack = state == DATA && m.m_ack;
    end

    assign if_stop = !if_valid;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            if_instr  <= '0;
            if_valid  <= 1'b0;
            d_rdata   <= '0;
            d_done    <= 1'b0;
            m.m_we    <= 1'b0;
            m.m_addr  <= '0;
            m.m_wdata <= '0;
        end else begin
            if_valid <= fetch_ok;
            d_done   <= data_ack;
            if (fetch_ok)
                if_instr <= m.m_rdata;
            if (data_ack && !m.m_we)
                d_rdata <= m.m_rdata;
            if (grant) begin
                m.m_addr  <= grant_data ? d_addr : if_addr;
                m.m_we    <= grant_data && d_we;
                m.m_wdata <= grant_data ? d_wdata : '0;
            end
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks against a transaction-level model
module tb_mem_port_arbiter;
    localparam int RUN = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_instr, d_rdata;
    logic        if_valid, if_stop, d_done;

    mem_port_arbiter_if m();

    mem_port_arbiter #(.MAX_DATA_RUN(RUN)) dut (
        .clk(clk), .reset(reset), .if_addr(if_addr), .if_flush(if_flush),
        .if_instr(if_instr), .if_valid(if_valid), .if_stop(if_stop),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .m(m)
    );

    always #5 clk = ~clk;

    int npass = 0, nfail = 0, ncheck = 0;

    // model: cur is the transaction on the bus (0 none, 1 fetch, 2 data)
    int          cur = 0, age = 0, run = 0, lat = 2;
    bit          disc = 0, e_valid = 0, e_done = 0, e_we = 0, granted = 0;
    logic [31:0] e_instr = '0, e_rdata = '0, e_addr = '0, e_wdata = '0;
    bit          stray_ack = 0, flush_on_ack = 0, drop_on_done = 0, rec = 0;
    string       pat = "";

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".if_valid"}, if_valid, e_valid);
        chk({tag, ".if_stop"}, if_stop, !e_valid);
        chk({tag, ".if_instr"}, if_instr, e_instr);
        chk({tag, ".d_done"}, d_done, e_done);
        chk({tag, ".d_rdata"}, d_rdata, e_rdata);
        chk({tag, ".m_req"}, m.m_req, cur != 0);
        chk({tag, ".m_addr"}, m.m_addr, e_addr);
        chk({tag, ".m_we"}, m.m_we, e_we);
        chk({tag, ".m_wdata"}, m.m_wdata, e_wdata);
    endtask

    task automatic model_reset();
        cur = 0; age = 0; run = 0; disc = 0; e_valid = 0; e_done = 0;
        e_we = 0; e_instr = '0; e_rdata = '0; e_addr = '0; e_wdata = '0;
    endtask

    task automatic cycle(string tag);
        logic        s_ack, s_flush, s_req, s_we;
        logic [31:0] s_ia, s_da, s_wd, s_rd;
        bit          take_data;
        m.m_ack = stray_ack || (cur != 0 && age >= lat);
        if (flush_on_ack && cur == 1 && m.m_ack) begin
            if_flush = 1'b1;
            if_addr  = 32'h40;
        end
        s_ack = m.m_ack; s_flush = if_flush; s_req = d_req; s_we = d_we;
        s_ia = if_addr; s_da = d_addr; s_wd = d_wdata; s_rd = m.m_rdata;
        @(posedge clk);
        granted   = cur == 0 || s_ack;
        take_data = s_req && !e_done && !(GUARD && run >= RUN);
        e_valid   = cur == 1 && s_ack && !disc && !s_flush;
        if (e_valid) e_instr = s_rd;
        e_done = cur == 2 && s_ack;
        if (e_done && !e_we) e_rdata = s_rd;
        if (cur == 1) disc = s_ack ? 1'b0 : (disc || s_flush);
        if (granted) begin
            cur     = take_data ? 2 : 1;
            e_addr  = take_data ? s_da : s_ia;
            e_we    = take_data && s_we;
            e_wdata = take_data ? s_wd : '0;
            run     = take_data ? (run < RUN ? run + 1 : RUN) : 0;
            age     = 0;
        end else if (cur != 0) age++;
        #1;
        check_all(tag);
        if (rec && granted) pat = {pat, (m.m_addr == 32'h300) ? "D" : "F"};
        m.m_ack = 1'b0;
        if_flush = 1'b0;
        stray_ack = 0;
        if (drop_on_done && e_done) d_req = 1'b0;
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        m.m_ack = 1'b0;
        m.m_rdata = '0;
        #1;
        model_reset();
        check_all("por");
        do_reset("rst");

        // single fetch at 0x0, latency 2
        m.m_rdata = 32'h00A00093;
        for (int i = 0; i < 8; i++) cycle("fetch");

        // data read arriving while a fetch is in flight
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        m.m_rdata = 32'hDEADBEEF;
        drop_on_done = 1;
        for (int i = 0; i < 12; i++) cycle("dread");

        // data write, d_rdata must hold
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
        lat = 3;
        for (int i = 0; i < 12; i++) cycle("dwrite");

        // flush on the fetch completion cycle, redirect to 0x40
        flush_on_ack = 1;
        for (int i = 0; i < 5; i++) cycle("flush");
        flush_on_ack = 0;
        for (int i = 0; i < 6; i++) cycle("refetch");

        // held data request: grant pattern
        do_reset("rst2");
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; if_addr = 32'hF00;
        drop_on_done = 0; lat = 1; pat = ""; rec = 1;
        for (int i = 0; i < 100 && pat.len() < 10; i++) cycle("run");
        rec = 0;
        ncheck++;
        assert (pat == (GUARD ? "DDDDFDDDDF" : "DDDDDDDDDD")) npass++;
        else begin
            nfail++;
            $error("FAIL grant_pattern: got %s, expected %s", pat, GUARD ? "DDDDFDDDDF" : "DDDDDDDDDD");
        end

        // reset in the middle of a data transaction, stray ack afterwards
        d_req = 1'b0; lat = 2;
        for (int i = 0; i < 4; i++) cycle("pre");
        d_req = 1'b1; d_addr = 32'h500;
        for (int i = 0; i < 20 && !(cur == 2 && age == 0); i++) cycle("towards_data");
        chk("reach_data", cur, 2);
        do_reset("mid_rst");
        d_req = 1'b0;
        stray_ack = 1;
        for (int i = 0; i < 6; i++) cycle("after_rst");

        // random traffic
        drop_on_done = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!d_req || e_done) begin
                d_req   = $urandom_range(0, 1) == 1;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            if ($urandom_range(0, 7) == 0) if_addr = $urandom;
            if_flush  = $urandom_range(0, 7) == 0;
            m.m_rdata = $urandom;
            cycle("rand");
            if (granted) lat = $urandom_range(1, 3);
        end

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end
endmodule
